reduce_tree_pipe: RTL and testbench

- Parametrised, pipelined bitwise reduction tree for the rounder path. Successor to the single-mode combinational AND tree.
- Reduces an N-bit operand to one bit with a per-transaction mode: AND, OR, XOR or NOR.
- Registers are inserted every REG_EVERY tree levels. Operands move through the stages under valid/ready flow control with full backpressure.
- Feeds sticky-bit, all-ones and zero-detect logic for the rounder.

---
 rtl/reduce_tree_pipe.sv | 119 +++++++++++
 tb/tb_reduce_tree_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reduce_tree_pipe.sv
// Pipelined AND/OR/XOR/NOR reduction tree with valid/ready flow control.
// A register stage follows every REG_EVERY tree levels; data width halves per level.

module reduce_tree_seg #(
  parameter int WI = 2,
  parameter int LV = 1
) (
  input  logic [WI-1:0]        d,
  input  logic [1:0]           mode,
  output logic [(WI>>LV)-1:0]  q
);
  localparam int WO = WI >> LV;

  // Heap layout: leaves at [2*WI-1:WI], node i combines children 2i and 2i+1.
  logic [2*WI-1:WO] t;

  always_comb begin
    t = '0;
    t[2*WI-1:WI] = d;
    for (int i = WI-1; i >= WO; i--) begin
      case (mode)
        2'b00:   t[i] = t[2*i] & t[2*i+1];
        2'b10:   t[i] = t[2*i] ^ t[2*i+1];
        default: t[i] = t[2*i] | t[2*i+1];
      endcase
    end
  end

  assign q = t[2*WO-1:WO];
endmodule

module reduce_tree_pipe #(
  parameter int N         = 11,
  parameter int REG_EVERY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         red_out,
  output logic [1:0]   out_mode
);
  localparam int L = $clog2(N);
  localparam int S = (L + REG_EVERY - 1) / REG_EVERY;
  localparam int P = 1 << L;

  logic [P-1:0]     leaf;
  logic [S:0]       vld_pipe;
  logic [S+1:1]     rdy;
  logic [S:0][1:0]  mode_pipe;

  // Pads are the identity of the level function: 1 for AND, 0 otherwise.
  always_comb begin
    leaf        = {P{mode == 2'b00}};
    leaf[N-1:0] = x;
  end

  assign vld_pipe[0]  = in_valid;
  assign mode_pipe[0] = mode;
  assign rdy[S+1]     = out_ready;
  assign in_ready     = rdy[1];

  for (genvar g = 0; g < S; g++) begin : stg
    localparam int LO = g * REG_EVERY;
    localparam int HI = ((g+1) * REG_EVERY < L) ? (g+1) * REG_EVERY : L;
    localparam int WI = 1 << (L - LO);
    localparam int WO = 1 << (L - HI);

    logic [WI-1:0] d;
    logic [WO-1:0] r, nxt, q;
    logic [1:0]    m;
    logic          v;

    if (g == 0) begin : g_first
      assign d = leaf;
    end else begin : g_rest
      assign d = stg[g-1].q;
    end

    reduce_tree_seg #(.WI(WI), .LV(HI - LO)) u_seg (
      .d    (d),
      .mode (mode_pipe[g]),
      .q    (r)
    );

    // NOR rides the OR tree and is inverted only when entering the last stage.
    if (g == S-1) begin : g_last
      assign nxt = r ^ {WO{mode_pipe[g] == 2'b11}};
    end else begin : g_mid
      assign nxt = r;
    end

    assign rdy[g+1]       = !v || rdy[g+2];
    assign vld_pipe[g+1]  = v;
    assign mode_pipe[g+1] = m;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= 1'b0;
        m <= 2'b00;
        q <= '0;
      end else if (rdy[g+1]) begin
        v <= vld_pipe[g];
        if (vld_pipe[g]) begin
          q <= nxt;
          m <= mode_pipe[g];
        end
      end
    end
  end

  assign out_valid = vld_pipe[S];
  assign out_mode  = mode_pipe[S];
  assign red_out   = stg[S-1].q[0];
endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Scoreboard bench: two builds (REG_EVERY=1 and 2) of the N=11 reduction pipe.
// Stimulus pushes hand-computed results; a negedge monitor pops and compares.

module tb_reduce_tree_pipe;
  localparam int S0 = 4;  // N=11, REG_EVERY=1
  localparam int S1 = 2;  // N=11, REG_EVERY=2

  typedef struct packed {
    logic        red;
    logic [1:0]  mode;
    logic        chk;
    logic [31:0] issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x = '0;
  logic [1:0]  mode = 2'b00;
  logic        iv[2];
  logic        ir[2];
  logic        ordy[2];
  logic        ov[2];
  logic        ro[2];
  logic [1:0]  om[2];

  exp_t        sb0[$];
  exp_t        sb1[$];
  int          ncmp = 0;
  int          nerr = 0;
  int          cyc = 0;
  logic        hold[2];
  logic        pr[2];
  logic [1:0]  pm[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reduce_tree_pipe #(.N(11), .REG_EVERY(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .x(x), .mode(mode),
    .out_valid(ov[0]), .out_ready(ordy[0]), .red_out(ro[0]), .out_mode(om[0])
  );

  reduce_tree_pipe #(.N(11), .REG_EVERY(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .x(x), .mode(mode),
    .out_valid(ov[1]), .out_ready(ordy[1]), .red_out(ro[1]), .out_mode(om[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   s;
    s = (d == 0) ? S0 : S1;
    if (hold[d]) begin
      check($sformatf("stall_valid%0d", d), {31'd0, ov[d]}, 32'd1);
      check($sformatf("stall_red%0d", d), {31'd0, ro[d]}, {31'd0, pr[d]});
      check($sformatf("stall_mode%0d", d), {30'd0, om[d]}, {30'd0, pm[d]});
    end
    if (ov[d] && ordy[d]) begin
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        check($sformatf("unexpected_out%0d", d), 32'd1, 32'd0);
      end else begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        check($sformatf("red%0d", d), {31'd0, ro[d]}, {31'd0, e.red});
        check($sformatf("mode%0d", d), {30'd0, om[d]}, {30'd0, e.mode});
        if (e.chk) check($sformatf("latency%0d", d), cyc - e.issue, s);
      end
    end
    hold[d] = ov[d] && !ordy[d];
    pr[d]   = ro[d];
    pm[d]   = om[d];
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      mon(0);
      mon(1);
    end
  end

  task automatic send(input int d, input logic [10:0] vx, input logic [1:0] vm,
                      input logic er, input logic chk);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    x = vx; mode = vm; iv[d] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir[d]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      e = '{red: er, mode: vm, chk: chk, issue: cyc};
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (sb0.size() != 0 || sb1.size() != 0); i++) @(posedge clk);
    #1;
    check("drain0", sb0.size(), 0);
    check("drain1", sb1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b1; ordy[1] = 1'b1;
    hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    check("rst_red_out", {31'd0, ro[0]}, 32'd0);
    check("rst_out_mode", {30'd0, om[0]}, 32'd0);
    check("rst_in_ready", {31'd0, ir[0]}, 32'd1);
    @(posedge clk); #1;

    // back-to-back AND, then mode sweep, padding and all-ones cases
    send(0, 11'h7FF, 2'b00, 1'b1, 1'b1);
    send(0, 11'h7DF, 2'b00, 1'b0, 1'b1);
    send(0, 11'h555, 2'b00, 1'b0, 1'b1);
    send(0, 11'h555, 2'b01, 1'b1, 1'b1);
    send(0, 11'h555, 2'b10, 1'b0, 1'b1);
    send(0, 11'h555, 2'b11, 1'b0, 1'b1);
    send(0, 11'h000, 2'b11, 1'b1, 1'b1);
    send(0, 11'h400, 2'b00, 1'b0, 1'b1);
    send(0, 11'h400, 2'b01, 1'b1, 1'b1);
    send(0, 11'h400, 2'b10, 1'b1, 1'b1);
    send(0, 11'h400, 2'b11, 1'b0, 1'b1);
    send(0, 11'h7FF, 2'b10, 1'b1, 1'b1);
    send(0, 11'h7FF, 2'b11, 1'b0, 1'b1);
    send(0, 11'h000, 2'b00, 1'b0, 1'b1);
    wait_idle();

    // backpressure: fill the pipe, confirm stall, then drain in order
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    send(0, 11'h001, 2'b01, 1'b1, 1'b0);
    send(0, 11'h003, 2'b10, 1'b0, 1'b0);
    send(0, 11'h7FF, 2'b00, 1'b1, 1'b0);
    send(0, 11'h000, 2'b11, 1'b1, 1'b0);
    x = 11'h007; mode = 2'b10; iv[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", {31'd0, ir[0]}, 32'd0);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    send(0, 11'h007, 2'b10, 1'b1, 1'b0);
    send(0, 11'h100, 2'b00, 1'b0, 1'b0);
    wait_idle();

    // reset with results in flight and one held at the output
    ordy[0] = 1'b0;
    send(0, 11'h7FF, 2'b01, 1'b1, 1'b0);
    send(0, 11'h7DF, 2'b00, 1'b0, 1'b0);
    send(0, 11'h555, 2'b10, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, ov[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, ov[0]}, 32'd0);
    check("async_rst_red", {31'd0, ro[0]}, 32'd0);
    check("async_rst_mode", {30'd0, om[0]}, 32'd0);
    sb0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, ir[0]}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    send(0, 11'h7FF, 2'b00, 1'b1, 1'b1);
    wait_idle();

    // REG_EVERY=2 build: two-cycle latency, same sweep results
    send(1, 11'h555, 2'b00, 1'b0, 1'b1);
    send(1, 11'h555, 2'b01, 1'b1, 1'b1);
    send(1, 11'h555, 2'b10, 1'b0, 1'b1);
    send(1, 11'h555, 2'b11, 1'b0, 1'b1);
    send(1, 11'h000, 2'b11, 1'b1, 1'b1);
    send(1, 11'h7FF, 2'b00, 1'b1, 1'b1);
    send(1, 11'h400, 2'b10, 1'b1, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
